// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the SoC bus arbiter: bus widths, FSM encoding and
// a one-hot to index helper.
package bus_arbiter_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Encodes a one-hot vector of up to four requesters into an index.
    function automatic logic [1:0] onehot4_to_index(input logic [3:0] onehot);
        logic [1:0] index;
        index = 2'd0;
        for (int i = 0; i < 4; i++) begin
            index = index | (2'(i) & {2{onehot[i]}});
        end
        return index;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer,
// wrapping, skipping any master in the exclusion mask.
module bus_arbiter_rr_pick #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] request,
    input  logic [IDX_W-1:0]       pointer,
    input  logic [NUM_MASTERS-1:0] exclude,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   valid
);

    // Walk the requesters in rotation order and keep only the first eligible one.
    always_comb begin
        int   slot;
        logic hit;
        slot  = 0;
        hit   = 1'b0;
        grant = '0;
        valid = 1'b0;
        for (int offset = 0; offset < NUM_MASTERS; offset++) begin
            slot         = (int'(pointer) + offset) % NUM_MASTERS;
            hit          = request[slot] & ~exclude[slot] & ~valid;
            grant[slot]  = grant[slot] | hit;
            valid        = valid | hit;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared peripheral/memory bus: one transaction in
// flight, held until slave ready or a timeout bus error.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              i_clock,
    input  logic                              i_reset_n,
    input  logic [NUM_MASTERS-1:0]            i_m_request,
    input  logic [NUM_MASTERS-1:0]            i_m_rw,
    input  logic [BUS_ADDR_W*NUM_MASTERS-1:0] i_m_address,
    input  logic [BUS_DATA_W*NUM_MASTERS-1:0] i_m_wdata,
    output logic [NUM_MASTERS-1:0]            o_m_ready,
    output logic [NUM_MASTERS-1:0]            o_m_error,
    output logic [BUS_DATA_W-1:0]             o_m_rdata,
    output logic                              o_s_request,
    output logic                              o_s_rw,
    output logic [BUS_ADDR_W-1:0]             o_s_address,
    output logic [BUS_DATA_W-1:0]             o_s_wdata,
    input  logic [BUS_DATA_W-1:0]             i_s_rdata,
    input  logic                              i_s_ready,
    output logic [NUM_MASTERS-1:0]            o_grant,
    output logic                              o_busy
);

    localparam int  IDX_W      = $clog2(NUM_MASTERS);
    localparam int  CNT_W      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam bit  TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0]       CNT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [NUM_MASTERS-1:0] ONE_M    = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

    state_t                  state_r, state_next_s;
    logic [IDX_W-1:0]        index_r, index_next_s;
    logic [IDX_W-1:0]        pointer_r, pointer_next_s;
    logic [NUM_MASTERS-1:0]  last_r, last_next_s;
    logic [CNT_W-1:0]        count_r, count_next_s;
    logic                    rw_r, rw_next_s;
    logic [BUS_ADDR_W-1:0]   addr_r, addr_next_s;
    logic [BUS_DATA_W-1:0]   wdata_r, wdata_next_s;
    logic [NUM_MASTERS-1:0]  grant_r, grant_next_s;
    logic                    s_request_r, s_request_next_s;
    logic                    busy_r, busy_next_s;
    logic [NUM_MASTERS-1:0]  m_ready_r, m_ready_next_s;
    logic [NUM_MASTERS-1:0]  m_error_r, m_error_next_s;
    logic [BUS_DATA_W-1:0]   m_rdata_r, m_rdata_next_s;

    logic [NUM_MASTERS-1:0]  pick_grant_s;
    logic                    pick_valid_s;
    logic [3:0]              pick_wide_s;
    logic [IDX_W-1:0]        pick_index_s;
    logic [NUM_MASTERS-1:0]  index_onehot_s;

    bus_arbiter_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_rr_pick (
        .request (i_m_request),
        .pointer (pointer_r),
        .exclude (last_r),
        .grant   (pick_grant_s),
        .valid   (pick_valid_s)
    );

    // Widen the picker grant so the shared encoder works for any legal master count.
    always_comb begin
        pick_wide_s                  = 4'd0;
        pick_wide_s[NUM_MASTERS-1:0] = pick_grant_s;
    end

    assign pick_index_s   = IDX_W'(onehot4_to_index(pick_wide_s));
    assign index_onehot_s = ONE_M << index_r;

    // Next-state and next-register computation for the IDLE/BUSY/DONE sequence.
    always_comb begin
        state_next_s     = state_r;
        index_next_s     = index_r;
        pointer_next_s   = pointer_r;
        last_next_s      = last_r;
        count_next_s     = count_r;
        rw_next_s        = rw_r;
        addr_next_s      = addr_r;
        wdata_next_s     = wdata_r;
        grant_next_s     = grant_r;
        s_request_next_s = s_request_r;
        busy_next_s      = busy_r;
        m_ready_next_s   = m_ready_r;
        m_error_next_s   = m_error_r;
        m_rdata_next_s   = m_rdata_r;
        case (state_r)
            ST_IDLE: begin
                // The exclusion only ever applies to the first IDLE cycle after a completion.
                last_next_s = '0;
                if (pick_valid_s) begin
                    state_next_s     = ST_BUSY;
                    index_next_s     = pick_index_s;
                    rw_next_s        = i_m_rw[pick_index_s];
                    addr_next_s      = i_m_address[int'(pick_index_s)*BUS_ADDR_W +: BUS_ADDR_W];
                    wdata_next_s     = i_m_wdata[int'(pick_index_s)*BUS_DATA_W +: BUS_DATA_W];
                    grant_next_s     = pick_grant_s;
                    s_request_next_s = 1'b1;
                    busy_next_s      = 1'b1;
                    count_next_s     = '0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (count_r != '1) begin
                    count_next_s = count_r + CNT_W'(1);
                end else begin
                    count_next_s = count_r;
                end
                if (i_s_ready) begin
                    state_next_s     = ST_DONE;
                    s_request_next_s = 1'b0;
                    busy_next_s      = 1'b0;
                    m_ready_next_s   = index_onehot_s;
                    m_error_next_s   = '0;
                    m_rdata_next_s   = i_s_rdata;
                end else if (TIMEOUT_EN && (count_r == CNT_LAST)) begin
                    state_next_s     = ST_DONE;
                    s_request_next_s = 1'b0;
                    busy_next_s      = 1'b0;
                    m_ready_next_s   = index_onehot_s;
                    m_error_next_s   = index_onehot_s;
                    m_rdata_next_s   = '0;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_next_s   = ST_IDLE;
                pointer_next_s = (index_r == IDX_W'(NUM_MASTERS - 1)) ? '0 : index_r + IDX_W'(1);
                last_next_s    = index_onehot_s;
                count_next_s   = '0;
                grant_next_s   = '0;
                m_ready_next_s = '0;
                m_error_next_s = '0;
                m_rdata_next_s = '0;
            end
            default: begin
                state_next_s     = ST_IDLE;
                grant_next_s     = '0;
                s_request_next_s = 1'b0;
                busy_next_s      = 1'b0;
                m_ready_next_s   = '0;
                m_error_next_s   = '0;
                m_rdata_next_s   = '0;
                count_next_s     = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_r     <= ST_IDLE;
            index_r     <= '0;
            pointer_r   <= '0;
            last_r      <= '0;
            count_r     <= '0;
            rw_r        <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= '0;
            grant_r     <= '0;
            s_request_r <= 1'b0;
            busy_r      <= 1'b0;
            m_ready_r   <= '0;
            m_error_r   <= '0;
            m_rdata_r   <= '0;
        end else begin
            state_r     <= state_next_s;
            index_r     <= index_next_s;
            pointer_r   <= pointer_next_s;
            last_r      <= last_next_s;
            count_r     <= count_next_s;
            rw_r        <= rw_next_s;
            addr_r      <= addr_next_s;
            wdata_r     <= wdata_next_s;
            grant_r     <= grant_next_s;
            s_request_r <= s_request_next_s;
            busy_r      <= busy_next_s;
            m_ready_r   <= m_ready_next_s;
            m_error_r   <= m_error_next_s;
            m_rdata_r   <= m_rdata_next_s;
        end
    end

    assign o_m_ready   = m_ready_r;
    assign o_m_error   = m_error_r;
    assign o_m_rdata   = m_rdata_r;
    assign o_s_request = s_request_r;
    assign o_s_rw      = rw_r;
    assign o_s_address = addr_r;
    assign o_s_wdata   = wdata_r;
    assign o_grant     = grant_r;
    assign o_busy      = busy_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: expected completions are queued when a
// transaction is launched and matched against every o_m_ready pulse.
module tb_bus_arbiter;

    localparam int N  = 2;
    localparam int TO = 16;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [N-1:0]    m_request;
    logic [N-1:0]    m_rw;
    logic [N*32-1:0] m_address;
    logic [N*32-1:0] m_wdata;
    logic [N-1:0]    o_m_ready;
    logic [N-1:0]    o_m_error;
    logic [31:0]     o_m_rdata;
    logic            o_s_request;
    logic            o_s_rw;
    logic [31:0]     o_s_address;
    logic [31:0]     o_s_wdata;
    logic [31:0]     i_s_rdata;
    logic            i_s_ready;
    logic [N-1:0]    o_grant;
    logic            o_busy;

    typedef struct {
        logic [N-1:0] mask;
        logic [31:0]  rdata;
        logic         err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   pulses = 0;

    always #5 clock = ~clock;

    bus_arbiter #(
        .NUM_MASTERS    (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clock     (clock),
        .i_reset_n   (reset_n),
        .i_m_request (m_request),
        .i_m_rw      (m_rw),
        .i_m_address (m_address),
        .i_m_wdata   (m_wdata),
        .o_m_ready   (o_m_ready),
        .o_m_error   (o_m_error),
        .o_m_rdata   (o_m_rdata),
        .o_s_request (o_s_request),
        .o_s_rw      (o_s_rw),
        .o_s_address (o_s_address),
        .o_s_wdata   (o_s_wdata),
        .i_s_rdata   (i_s_rdata),
        .i_s_ready   (i_s_ready),
        .o_grant     (o_grant),
        .o_busy      (o_busy)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic sb_push(input int m, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.mask  = N'(32'd1 << m);
        e.rdata = rdata;
        e.err   = err;
        sb_q.push_back(e);
        pushed++;
    endtask

    // Completion monitor: pop the oldest expectation on each ready pulse.
    always @(negedge clock) begin
        if (o_m_ready != '0) begin
            pulses++;
            if (sb_q.size() == 0) begin
                check_value("unexpected_ready", 32'(o_m_ready), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_value("ready_master", 32'(o_m_ready), 32'(mon_e.mask));
                check_value("ready_rdata", o_m_rdata, mon_e.rdata);
                check_value("ready_error", 32'(o_m_error), mon_e.err ? 32'(mon_e.mask) : 32'd0);
            end
        end else begin
            check_value("idle_error", 32'(o_m_error), 32'd0);
            check_value("idle_rdata", o_m_rdata, 32'd0);
        end
    end

    task automatic check_all_zero(input string tag);
        check_value(tag, 32'({o_m_ready, o_m_error, o_s_request, o_s_rw, o_grant, o_busy}), 32'd0);
        check_value({tag, "_addr"}, o_s_address, 32'd0);
        check_value({tag, "_wdata"}, o_s_wdata, 32'd0);
        check_value({tag, "_rdata"}, o_m_rdata, 32'd0);
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        m_request = '0;
        m_rw      = '0;
        m_address = '0;
        m_wdata   = '0;
        i_s_ready = 1'b0;
        i_s_rdata = 32'd0;
        @(negedge clock);
        @(negedge clock);
        check_all_zero("reset");
        reset_n = 1'b1;
    endtask

    task automatic wait_s_request(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (o_s_request !== 1'b1 && n < 20);
    endtask

    // ready_delay < 0 means the slave never answers.
    task automatic run_txn(input int m, input logic rw, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ready_delay,
                           input logic [31:0] rdata, input logic exp_err,
                           input int exp_lat, input bit scramble);
        int n;
        int lat;
        bit stable;
        m_request[m]        = 1'b1;
        m_rw[m]             = rw;
        m_address[m*32+:32] = addr;
        m_wdata[m*32+:32]   = wdata;
        sb_push(m, exp_err ? 32'd0 : rdata, exp_err);
        wait_s_request(n);
        check_value("s_req_latency", n, 32'd1);
        check_value("grant", 32'(o_grant), 32'd1 << m);
        check_value("busy", 32'(o_busy), 32'd1);
        check_value("s_address", o_s_address, addr);
        check_value("s_wdata", o_s_wdata, wdata);
        check_value("s_rw", 32'(o_s_rw), 32'(rw));
        i_s_rdata = rdata;
        if (ready_delay == 0) i_s_ready = 1'b1;
        lat    = 0;
        stable = 1'b1;
        while (lat < 40) begin
            @(negedge clock);
            lat++;
            if (o_m_ready != '0) break;
            if (o_s_request !== 1'b1 || o_s_address !== addr || o_s_wdata !== wdata || o_s_rw !== rw)
                stable = 1'b0;
            if (lat == ready_delay) i_s_ready = 1'b1;
            if (scramble) begin
                m_address[m*32+:32] = addr ^ (32'(lat) << 20);
                m_wdata[m*32+:32]   = wdata ^ 32'(lat);
            end
        end
        check_value("ready_latency", lat, exp_lat);
        check_value("s_stable", 32'(stable), 32'd1);
        m_request[m] = 1'b0;
        i_s_ready    = 1'b0;
        i_s_rdata    = 32'd0;
        @(negedge clock);
        check_value("post_done", 32'({o_grant, o_busy, o_s_request, o_m_ready}), 32'd0);
        @(negedge clock);
    endtask

    initial begin
        int n;
        int got;
        apply_reset();

        // Single master read, slave ready two cycles in.
        run_txn(0, 1'b0, 32'h0001_0004, 32'd0, 2, 32'hCAFE_F00D, 1'b0, 3, 1'b0);

        // Both masters held requesting from reset: grants 0,1,0,1 every 3 cycles.
        apply_reset();
        m_request             = 2'b11;
        m_rw                  = 2'b00;
        m_address[31:0]       = 32'h0000_1000;
        m_address[63:32]      = 32'h0000_2000;
        sb_push(0, 32'h0000_1000 ^ 32'hA5A5_0000, 1'b0);
        sb_push(1, 32'h0000_2000 ^ 32'hA5A5_0000, 1'b0);
        sb_push(0, 32'h0000_1000 ^ 32'hA5A5_0000, 1'b0);
        sb_push(1, 32'h0000_2000 ^ 32'hA5A5_0000, 1'b0);
        n   = 0;
        got = 0;
        while (got < 4 && n < 60) begin
            @(negedge clock);
            n++;
            if (o_m_ready != '0) got++;
            i_s_ready = o_s_request;
            i_s_rdata = o_s_request ? (o_s_address ^ 32'hA5A5_0000) : 32'd0;
        end
        check_value("rr_pulses", got, 32'd4);
        check_value("rr_cycles", n, 32'd11);
        m_request = '0;
        i_s_ready = 1'b0;
        i_s_rdata = 32'd0;
        @(negedge clock);
        @(negedge clock);

        // Write from m1 with its inputs changing while the transaction is in flight.
        run_txn(1, 1'b1, 32'h5000_0000, 32'h0000_03FF, 4, 32'h1111_2222, 1'b0, 5, 1'b1);

        // Unmapped read: timeout error after exactly TO cycles, rdata forced to zero.
        run_txn(0, 1'b0, 32'h6000_0000, 32'd0, -1, 32'hDEAD_BEEF, 1'b1, TO, 1'b0);

        // Slave ready on the timeout cycle itself: ready wins.
        run_txn(0, 1'b0, 32'h6000_0004, 32'd0, TO - 1, 32'h5A5A_1234, 1'b0, TO, 1'b0);

        // Reset while BUSY aborts silently; pointer restarts at m0.
        m_request[1]     = 1'b1;
        m_rw[1]          = 1'b1;
        m_address[63:32] = 32'h7000_0000;
        m_wdata[63:32]   = 32'h0000_DEAD;
        wait_s_request(n);
        check_value("abort_s_req_latency", n, 32'd1);
        check_value("abort_grant", 32'(o_grant), 32'd2);
        reset_n = 1'b0;
        @(negedge clock);
        check_all_zero("abort");
        m_request = '0;
        @(negedge clock);
        reset_n          = 1'b1;
        m_request        = 2'b11;
        m_rw             = 2'b00;
        m_address[31:0]  = 32'h0000_0040;
        m_address[63:32] = 32'h0000_0080;
        sb_push(0, 32'h1234_5678, 1'b0);
        wait_s_request(n);
        check_value("post_rst_latency", n, 32'd1);
        check_value("post_rst_grant", 32'(o_grant), 32'd1);
        check_value("post_rst_addr", o_s_address, 32'h0000_0040);
        i_s_ready = 1'b1;
        i_s_rdata = 32'h1234_5678;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (o_m_ready == '0 && n < 20);
        check_value("post_rst_ready_latency", n, 32'd1);
        m_request = '0;
        i_s_ready = 1'b0;
        i_s_rdata = 32'd0;
        @(negedge clock);
        @(negedge clock);

        check_value("pulse_count", pulses, pushed);
        check_value("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

endmodule
